impulse_checker: RTL and testbench

- AXI4-Stream sink for the impulse test path. Consumes complex, multi-sample-per-clock frames such as those produced by the impulse generator or by the PFB/FFT output under impulse stimulus.
- Tracks frame position, checks tlast alignment, and locates the single nonzero (impulse) sample in each frame.
- Reports per-frame phase/value, match status and running counters to the bench or to status registers.

---
 rtl/impulse_pkg.sv | 38 +++
 rtl/beat_nz_encoder.sv | 34 +++
 rtl/impulse_checker.sv | 158 +++++++++++++++
 tb/tb_impulse_checker.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/impulse_pkg.sv
`default_nettype none
//============================================================================
// Package  : impulse_pkg
// Brief    : Shared sample/beat types and helpers for the impulse test path.
// Revision : 1.0
//============================================================================
package impulse_pkg;

    localparam int WIDTH        = 16;
    localparam int SAMP_PER_CLK = 2;
    localparam int CMPX         = 2;
    localparam int TDATA_WID    = CMPX * SAMP_PER_CLK * WIDTH;
    localparam int K_W          = (SAMP_PER_CLK > 1) ? $clog2(SAMP_PER_CLK) : 1;

    typedef struct packed {
        logic signed [WIDTH-1:0] im;
        logic signed [WIDTH-1:0] re;
    } cx_t;

    typedef cx_t [SAMP_PER_CLK-1:0] beat_t;

    typedef enum logic [0:0] {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } state_t;

    function automatic logic is_nz(input cx_t s);
        return (s.re != '0) || (s.im != '0);
    endfunction

    function automatic logic [1:0] nz_sat_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 3'd3) ? 2'd3 : s[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/beat_nz_encoder.sv
`default_nettype none
//============================================================================
// Module   : beat_nz_encoder
// Brief    : Finds the lowest-index nonzero sample in one beat and counts them.
// Revision : 1.0
//============================================================================
module beat_nz_encoder
    import impulse_pkg::*;
(
    input  beat_t          i_beat,
    output logic           o_any_nz,
    output logic [K_W-1:0] o_first_k,
    output cx_t            o_first_smp,
    output logic [1:0]     o_nz_cnt
);

    always_comb begin
        o_any_nz    = 1'b0;
        o_first_k   = '0;
        o_first_smp = '0;
        o_nz_cnt    = '0;
        // Descending scan: the lowest-index nonzero sample is the last one written.
        for (int k = SAMP_PER_CLK - 1; k >= 0; k--) begin
            if (is_nz(i_beat[k])) begin
                o_any_nz    = 1'b1;
                o_first_k   = K_W'(k);
                o_first_smp = i_beat[k];
                o_nz_cnt    = nz_sat_add(o_nz_cnt, 2'd1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/impulse_checker.sv
`default_nettype none
//============================================================================
// Module   : impulse_checker
// Brief    : AXI4-Stream sink that locates and checks the impulse in each frame.
// Revision : 1.0
//============================================================================
module impulse_checker #(
    parameter int WIDTH         = impulse_pkg::WIDTH,
    parameter int SAMP_PER_CLK  = impulse_pkg::SAMP_PER_CLK,
    parameter int FFT_LEN       = 64,
    parameter int EXP_PHA       = 0,
    parameter int EXP_VAL       = 64,
    parameter int SYNC_ON_TLAST = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [2*SAMP_PER_CLK*WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic                            hold,
    output logic                            frame_done,
    output logic                            impulse_found,
    output logic [$clog2(FFT_LEN)-1:0]      impulse_pha,
    output logic [WIDTH-1:0]                impulse_re,
    output logic [WIDTH-1:0]                impulse_im,
    output logic                            match,
    output logic                            tlast_err,
    output logic                            multi_err,
    output logic [31:0]                     frame_cnt,
    output logic [15:0]                     err_cnt
);
    import impulse_pkg::*;

    localparam int c_beats = FFT_LEN / SAMP_PER_CLK;
    localparam int CNT_W   = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int PHA_W   = $clog2(FFT_LEN);
    localparam logic [CNT_W-1:0]        c_last_beat  = CNT_W'(c_beats - 1);
    localparam logic [PHA_W-1:0]        c_exp_pha    = PHA_W'(EXP_PHA);
    localparam logic signed [WIDTH-1:0] c_exp_val    = WIDTH'(EXP_VAL);
    localparam state_t                  c_init_state = (SYNC_ON_TLAST != 0) ? ST_ACQUIRE : ST_TRACK;

    state_t             r_state, w_state_nxt;
    logic               r_ready;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_acc_found;
    logic [PHA_W-1:0]   r_acc_pha;
    cx_t                r_acc_smp;
    logic [1:0]         r_acc_nz;

    beat_t              w_beat;
    logic               w_enc_any;
    logic [K_W-1:0]     w_enc_k;
    cx_t                w_enc_smp;
    logic [1:0]         w_enc_cnt;
    logic               w_accept, w_trk_beat, w_at_last, w_close;
    logic [PHA_W-1:0]   w_beat_pha, w_fin_pha;
    logic               w_fin_found, w_match, w_multi, w_terr;
    cx_t                w_fin_smp;
    logic [1:0]         w_fin_nz;

    assign w_beat        = beat_t'(s_axis_tdata);
    assign s_axis_tready = r_ready;

    beat_nz_encoder u_enc (
        .i_beat      (w_beat),
        .o_any_nz    (w_enc_any),
        .o_first_k   (w_enc_k),
        .o_first_smp (w_enc_smp),
        .o_nz_cnt    (w_enc_cnt)
    );

    assign w_accept    = s_axis_tvalid && r_ready;
    assign w_trk_beat  = w_accept && (r_state == ST_TRACK);
    assign w_at_last   = (r_cnt == c_last_beat);
    assign w_close     = w_trk_beat && (w_at_last || s_axis_tlast);
    assign w_beat_pha  = PHA_W'(r_cnt) * PHA_W'(SAMP_PER_CLK) + PHA_W'(w_enc_k);

    // Frame result as it stands including the current beat; used both to
    // close the frame and to update the running accumulators.
    assign w_fin_found = r_acc_found || w_enc_any;
    assign w_fin_pha   = r_acc_found ? r_acc_pha : (w_enc_any ? w_beat_pha : '0);
    assign w_fin_smp   = r_acc_found ? r_acc_smp : w_enc_smp;
    assign w_fin_nz    = nz_sat_add(r_acc_nz, w_enc_cnt);
    assign w_multi     = (w_fin_nz >= 2'd2);
    assign w_match     = (w_fin_nz == 2'd1) && (w_fin_pha == c_exp_pha) &&
                         (w_fin_smp.re == c_exp_val) && (w_fin_smp.im == '0);
    assign w_terr      = s_axis_tlast ^ w_at_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_init_state;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACQUIRE: if (w_accept && s_axis_tlast) w_state_nxt = ST_TRACK;
            ST_TRACK:   w_state_nxt = ST_TRACK;
            default:    w_state_nxt = c_init_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready       <= 1'b0;
            r_cnt         <= '0;
            r_acc_found   <= 1'b0;
            r_acc_pha     <= '0;
            r_acc_smp     <= '0;
            r_acc_nz      <= '0;
            frame_done    <= 1'b0;
            tlast_err     <= 1'b0;
            impulse_found <= 1'b0;
            impulse_pha   <= '0;
            impulse_re    <= '0;
            impulse_im    <= '0;
            match         <= 1'b0;
            multi_err     <= 1'b0;
            frame_cnt     <= '0;
            err_cnt       <= '0;
        end else begin
            r_ready    <= !hold;
            frame_done <= 1'b0;
            tlast_err  <= 1'b0;
            if (w_close) begin
                r_cnt         <= '0;
                r_acc_found   <= 1'b0;
                r_acc_pha     <= '0;
                r_acc_smp     <= '0;
                r_acc_nz      <= '0;
                frame_done    <= 1'b1;
                tlast_err     <= w_terr;
                impulse_found <= w_fin_found;
                impulse_pha   <= w_fin_pha;
                impulse_re    <= w_fin_smp.re;
                impulse_im    <= w_fin_smp.im;
                match         <= w_match;
                multi_err     <= w_multi;
                frame_cnt     <= frame_cnt + 32'd1;
                if ((w_terr || w_multi || !w_match) && (err_cnt != 16'hFFFF)) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end else if (w_trk_beat) begin
                r_cnt       <= r_cnt + CNT_W'(1);
                r_acc_found <= w_fin_found;
                r_acc_pha   <= w_fin_pha;
                r_acc_smp   <= w_fin_smp;
                r_acc_nz    <= w_fin_nz;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_impulse_checker.sv
`default_nettype none
//============================================================================
// Module   : tb_impulse_checker
// Brief    : Self-checking bench: frame table plus a frame-level scoreboard.
// Revision : 1.0
//============================================================================
module tb_impulse_checker;

    localparam int FFT_LEN = 64;
    localparam int SPC     = 2;
    localparam int NB      = FFT_LEN / SPC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] tdata = '0;
    logic        tvalid = 1'b0, tlast = 1'b0, hold = 1'b0;

    logic        tready, frame_done, impulse_found, match, tlast_err, multi_err;
    logic [5:0]  impulse_pha;
    logic [15:0] impulse_re, impulse_im, err_cnt;
    logic [31:0] frame_cnt;
    logic        tready_b, frame_done_b, impulse_found_b, match_b, tlast_err_b, multi_err_b;
    logic [5:0]  impulse_pha_b;
    logic [15:0] impulse_re_b, impulse_im_b, err_cnt_b;
    logic [31:0] frame_cnt_b;

    always #5 clk = ~clk;

    impulse_checker u_dut (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready), .s_axis_tlast(tlast), .hold(hold),
        .frame_done(frame_done), .impulse_found(impulse_found), .impulse_pha(impulse_pha),
        .impulse_re(impulse_re), .impulse_im(impulse_im), .match(match),
        .tlast_err(tlast_err), .multi_err(multi_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    impulse_checker #(.EXP_PHA(37)) u_dut37 (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready_b), .s_axis_tlast(tlast), .hold(hold),
        .frame_done(frame_done_b), .impulse_found(impulse_found_b), .impulse_pha(impulse_pha_b),
        .impulse_re(impulse_re_b), .impulse_im(impulse_im_b), .match(match_b),
        .tlast_err(tlast_err_b), .multi_err(multi_err_b), .frame_cnt(frame_cnt_b), .err_cnt(err_cnt_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame stimulus table: impulse/second sample/tlast beat plus hand-derived results.
    typedef struct {
        int pha1; int re1; int im1; int pha2; int tl_beat;
        int e_found; int e_pha; int e_re; int e_im;
        int e_match; int e_match37; int e_multi; int e_terr;
    } vec_t;

    typedef struct {
        bit found; int pha; int re; int im;
        bit match; bit match37; bit multi; bit terr;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t eval_frame(input int re[FFT_LEN], input int im[FFT_LEN]);
        exp_t e;
        int   n;
        e = '{default: 0};
        n = 0;
        for (int i = 0; i < FFT_LEN; i++) begin
            if (re[i] != 0 || im[i] != 0) begin
                if (n == 0) begin
                    e.found = 1'b1; e.pha = i; e.re = re[i]; e.im = im[i];
                end
                n++;
            end
        end
        e.multi   = (n > 1);
        e.match   = (n == 1) && (e.pha == 0)  && (e.re == 64) && (e.im == 0);
        e.match37 = (n == 1) && (e.pha == 37) && (e.re == 64) && (e.im == 0);
        return e;
    endfunction

    // Reference model: own view of tready, sync state and beat position.
    bit m_ready = 1'b0;
    bit m_track = 1'b0;
    int m_cnt   = 0;
    int f_re[FFT_LEN];
    int f_im[FFT_LEN];

    initial forever begin
        bit   m_acc;
        exp_t e;
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_ready = 1'b0; m_track = 1'b0; m_cnt = 0;
            foreach (f_re[i]) begin f_re[i] = 0; f_im[i] = 0; end
        end else begin
            m_acc   = tvalid && m_ready;
            m_ready = !hold;
            if (m_acc && !m_track) begin
                if (tlast) m_track = 1'b1;
            end else if (m_acc) begin
                for (int k = 0; k < SPC; k++) begin
                    f_re[m_cnt*SPC+k] = $signed(tdata[k*32 +: 16]);
                    f_im[m_cnt*SPC+k] = $signed(tdata[k*32+16 +: 16]);
                end
                if (m_cnt == NB-1 || tlast) begin
                    e = eval_frame(f_re, f_im);
                    e.terr = (tlast != (m_cnt == NB-1));
                    sb.push_back(e);
                    m_cnt = 0;
                    foreach (f_re[i]) begin f_re[i] = 0; f_im[i] = 0; end
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Monitor: pops one frame result per close and checks every output each cycle.
    exp_t held = '{default: 0};
    int   e_frames = 0, e_errs = 0, e_errs37 = 0;
    int   cyc = 0, last_done = -1;
    bit   spc_en = 1'b0;

    initial forever begin
        bit d;
        @(negedge clk);
        cyc++;
        d = 1'b0;
        if (!rst) begin
            sb.delete();
            held = '{default: 0};
            e_frames = 0; e_errs = 0; e_errs37 = 0;
        end else if (sb.size() != 0) begin
            held = sb.pop_front();
            d = 1'b1;
            e_frames++;
            if (held.terr || held.multi || !held.match)   e_errs++;
            if (held.terr || held.multi || !held.match37) e_errs37++;
        end
        chk("tready",        tready,                  m_ready);
        chk("frame_done",    frame_done,              d);
        chk("tlast_err",     tlast_err,               d && held.terr);
        chk("impulse_found", impulse_found,           held.found);
        chk("impulse_pha",   impulse_pha,             held.pha);
        chk("impulse_re",    $signed(impulse_re),     held.re);
        chk("impulse_im",    $signed(impulse_im),     held.im);
        chk("match",         match,                   held.match);
        chk("multi_err",     multi_err,               held.multi);
        chk("frame_cnt",     frame_cnt,               e_frames);
        chk("err_cnt",       err_cnt,                 e_errs);
        chk("b_tready",      tready_b,                m_ready);
        chk("b_frame_done",  frame_done_b,            d);
        chk("b_tlast_err",   tlast_err_b,             d && held.terr);
        chk("b_found",       impulse_found_b,         held.found);
        chk("b_pha",         impulse_pha_b,           held.pha);
        chk("b_re",          $signed(impulse_re_b),   held.re);
        chk("b_im",          $signed(impulse_im_b),   held.im);
        chk("b_match37",     match_b,                 held.match37);
        chk("b_multi_err",   multi_err_b,             held.multi);
        chk("b_frame_cnt",   frame_cnt_b,             e_frames);
        chk("b_err_cnt",     err_cnt_b,               e_errs37);
        if (frame_done) begin
            if (spc_en && last_done >= 0) chk("done_spacing", cyc - last_done, NB);
            last_done = spc_en ? cyc : -1;
        end
    end

    bit hold_mode = 1'b0;
    bit gaps      = 1'b0;
    int hcnt      = 0;

    initial forever begin
        @(posedge clk); #1;
        if (hold_mode) begin
            hcnt++;
            if (hcnt == 3) begin hcnt = 0; hold = !hold; end
        end else begin
            hold = 1'b0; hcnt = 0;
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic l);
        bit a;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                tvalid = 1'b0; tdata = {$urandom, $urandom}; tlast = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        tvalid = 1'b1; tdata = d; tlast = l;
        a = 1'b0;
        for (int t = 0; t < 64 && !a; t++) begin
            @(negedge clk); a = tready;
            @(posedge clk); #1;
        end
        if (!a) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input vec_t v, input int b0, input int b1);
        int re[FFT_LEN];
        int im[FFT_LEN];
        foreach (re[i]) begin re[i] = 0; im[i] = 0; end
        if (v.pha1 >= 0) begin re[v.pha1] = v.re1; im[v.pha1] = v.im1; end
        if (v.pha2 >= 0) re[v.pha2] = 1;
        for (int b = b0; b <= b1; b++) begin
            drive_beat({16'(im[2*b+1]), 16'(re[2*b+1]), 16'(im[2*b]), 16'(re[2*b])},
                       (b == v.tl_beat));
        end
    endtask

    function automatic int last_beat_of(input vec_t v);
        return (v.tl_beat >= 0) ? v.tl_beat : NB-1;
    endfunction

    task automatic idle();
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            seen = frame_done;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{ 0,  64,  0, -1, 31,  1,  0,  64,  0, 1, 0, 0, 0};
        tbl[1] = '{37,  64,  0, -1, 31,  1, 37,  64,  0, 0, 1, 0, 0};
        tbl[2] = '{37,  63,  0, -1, 31,  1, 37,  63,  0, 0, 0, 0, 0};
        tbl[3] = '{ 4,  10, -5,  5, 31,  1,  4,  10, -5, 0, 0, 1, 0};
        tbl[4] = '{ 0,  64,  0, -1, 20,  1,  0,  64,  0, 1, 0, 0, 1};
        tbl[5] = '{ 0,  64,  0, -1, 31,  1,  0,  64,  0, 1, 0, 0, 0};
        tbl[6] = '{63,  -1,  0, -1, -1,  1, 63,  -1,  0, 0, 0, 0, 1};
        tbl[7] = '{-1,   0,  0, -1, 31,  0,  0,   0,  0, 0, 0, 0, 0};
        tbl[8] = '{10,   0, 64, -1, 31,  1, 10,   0, 64, 0, 0, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready",    tready, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_found",     impulse_found, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Stream joins mid-frame: beats 10..31 must be swallowed while acquiring.
        send_frame(tbl[0], 10, 31);
        idle();
        repeat (3) @(negedge clk);
        chk("acq_frame_cnt", frame_cnt, 0);
        @(posedge clk); #1;

        spc_en = 1'b1;
        repeat (4) send_frame(tbl[0], 0, NB-1);
        idle();
        repeat (3) @(negedge clk);
        spc_en = 1'b0;
        chk("b2b_frame_cnt", frame_cnt, 4);
        chk("b2b_err_cnt",   err_cnt, 0);
        chk("b2b_pha",       impulse_pha, 0);
        chk("b2b_re",        $signed(impulse_re), 64);
        chk("b2b_match",     match, 1);
        @(posedge clk); #1;

        for (int pass = 0; pass < 2; pass++) begin
            hold_mode = (pass == 1);
            gaps      = (pass == 1);
            for (int i = 0; i < 9; i++) begin
                send_frame(tbl[i], 0, last_beat_of(tbl[i]));
                idle();
                wait_done();
                chk("tbl_found",   impulse_found, tbl[i].e_found);
                chk("tbl_pha",     impulse_pha, tbl[i].e_pha);
                chk("tbl_re",      $signed(impulse_re), tbl[i].e_re);
                chk("tbl_im",      $signed(impulse_im), tbl[i].e_im);
                chk("tbl_match",   match, tbl[i].e_match);
                chk("tbl_match37", match_b, tbl[i].e_match37);
                chk("tbl_multi",   multi_err, tbl[i].e_multi);
                chk("tbl_terr",    tlast_err, tbl[i].e_terr);
                @(posedge clk); #1;
            end
        end
        hold_mode = 1'b0;
        gaps      = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame: partial frame vanishes, no frame_done for it.
        send_frame(tbl[0], 0, 9);
        idle();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_tready",    tready, 0);
        chk("mrst_frame_cnt", frame_cnt, 0);
        chk("mrst_err_cnt",   err_cnt, 0);
        chk("mrst_found",     impulse_found, 0);
        chk("mrst_done",      frame_done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        send_frame(tbl[0], 0, NB-1);
        send_frame(tbl[0], 0, NB-1);
        idle();
        wait_done();
        chk("post_rst_frame_cnt", frame_cnt, 1);
        chk("post_rst_match",     match, 1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
